vsc8541_smi_ctrl: RTL and testbench

- Sequencer and arbiter in front of the VSC8541 SMI/MDIO engine. The engine handles one MDIO frame per `i_en` pulse and holds its inputs unsampled-stable for the whole frame.
- After reset, waits for the engine's preamble, writes a parameterised PHY init table, then polls register 1 (status) periodically.
- Shares the engine with one host requester.
- Exposes link status and host read/write completion.

---
 rtl/vsc8541_smi_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_vsc8541_smi_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsc8541_smi_ctrl.sv
// ============================================================================
// vsc8541_smi_ctrl : init-table sequencer, status poller and host arbiter
//                    in front of the VSC8541 SMI/MDIO frame engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module vsc8541_smi_ctrl #(
   parameter logic [4:0] PHY_ADDR      = 5'd0,
   parameter int         INIT_LEN      = 4,
   parameter logic [((INIT_LEN > 0) ? INIT_LEN : 1)*21-1:0] INIT_TABLE = '0,
   parameter int         POLL_DIV      = 1000,
   parameter int         STARTUP_EDGES = 8,
   parameter int         TXN_EDGES     = 33
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_mdc,
   output logic        o_smi_en,
   output logic        o_smi_mode,
   output logic [4:0]  o_smi_phy_addr,
   output logic [4:0]  o_smi_reg_addr,
   output logic [15:0] o_smi_data,
   input  logic        i_smi_dv,
   input  logic [15:0] i_smi_data,
   input  logic        i_req,
   input  logic        i_req_mode,
   input  logic [4:0]  i_req_reg_addr,
   input  logic [15:0] i_req_data,
   output logic        o_req_ack,
   output logic [15:0] o_req_data,
   output logic        o_init_done,
   output logic [15:0] o_status,
   output logic        o_link_up,
   output logic        o_busy
);

   localparam logic [15:0] START_LAST = 16'(STARTUP_EDGES - 1);
   localparam logic [15:0] TXN_LAST   = 16'(TXN_EDGES - 1);
   localparam logic [15:0] POLL_LAST  = 16'(POLL_DIV - 1);
   localparam logic [3:0]  INIT_LAST  = 4'(INIT_LEN - 1);
   localparam logic [4:0]  STATUS_REG = 5'd1;

   typedef enum logic [1:0] {
      ST_STARTUP   = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_IDLE      = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SRC_INIT = 2'd0,
      SRC_POLL = 2'd1,
      SRC_HOST = 2'd2
   } src_t;

   state_t      state, state_next;
   src_t        src;
   logic        mdc_q, dv_q, fall;
   logic [15:0] edge_cnt;
   logic [15:0] poll_cnt;
   logic [3:0]  init_idx;
   logic        poll_pend;
   logic        last_host;
   logic        cap_done;

   logic        load, frame_done, init_finish, host_req, poll_expire;
   src_t        ld_src;
   logic        ld_mode;
   logic [4:0]  ld_reg;
   logic [15:0] ld_data;
   logic [3:0]  sel_idx;
   logic [20:0] entry;
   logic [20:0] tbl [16];

   // Unpack the flat init table into a fixed 16-entry array so a 4-bit index fits exactly.
   for (genvar k = 0; k < 16; k++) begin : g_tbl
      if (k < INIT_LEN) begin : g_used
         assign tbl[k] = INIT_TABLE[k*21 +: 21];
      end else begin : g_unused
         assign tbl[k] = '0;
      end
   end

   assign fall           = mdc_q & ~i_mdc;
   assign o_smi_en       = (state == ST_ISSUE);
   assign o_busy         = (state == ST_WAIT_DONE);
   assign o_smi_phy_addr = PHY_ADDR;
   assign o_link_up      = o_status[2];
   // The ack cycle still sees the old request; masking it avoids re-granting a finished frame.
   assign host_req       = i_req & o_init_done & ~o_req_ack;
   assign poll_expire    = o_init_done & fall & (poll_cnt == POLL_LAST);
   assign sel_idx        = (state == ST_STARTUP) ? 4'd0 : (init_idx + 4'd1);
   assign entry          = tbl[sel_idx];

   always_comb begin
      state_next  = state;
      load        = 1'b0;
      ld_src      = SRC_INIT;
      ld_mode     = 1'b0;
      ld_reg      = 5'd0;
      ld_data     = 16'd0;
      frame_done  = 1'b0;
      init_finish = 1'b0;
      case (state)
         ST_STARTUP: begin
            if (fall && (edge_cnt == START_LAST)) begin
               if (INIT_LEN == 0) begin
                  init_finish = 1'b1;
                  state_next  = ST_IDLE;
               end else begin
                  load       = 1'b1;
                  ld_src     = SRC_INIT;
                  ld_mode    = 1'b1;
                  ld_reg     = entry[20:16];
                  ld_data    = entry[15:0];
                  state_next = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            state_next = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (fall && (edge_cnt == TXN_LAST)) begin
               frame_done = 1'b1;
               if ((src == SRC_INIT) && (init_idx != INIT_LAST)) begin
                  load       = 1'b1;
                  ld_src     = SRC_INIT;
                  ld_mode    = 1'b1;
                  ld_reg     = entry[20:16];
                  ld_data    = entry[15:0];
                  state_next = ST_ISSUE;
               end else begin
                  init_finish = (src == SRC_INIT);
                  state_next  = ST_IDLE;
               end
            end
         end
         ST_IDLE: begin
            if (host_req && (!poll_pend || !last_host)) begin
               load       = 1'b1;
               ld_src     = SRC_HOST;
               ld_mode    = i_req_mode;
               ld_reg     = i_req_reg_addr;
               ld_data    = i_req_data;
               state_next = ST_ISSUE;
            end else if (poll_pend) begin
               load       = 1'b1;
               ld_src     = SRC_POLL;
               ld_mode    = 1'b0;
               ld_reg     = STATUS_REG;
               ld_data    = 16'd0;
               state_next = ST_ISSUE;
            end
         end
         default: state_next = ST_STARTUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state          <= ST_STARTUP;
         src            <= SRC_INIT;
         mdc_q          <= 1'b0;
         dv_q           <= 1'b0;
         edge_cnt       <= 16'd0;
         poll_cnt       <= 16'd0;
         init_idx       <= 4'd0;
         poll_pend      <= 1'b0;
         last_host      <= 1'b0;
         cap_done       <= 1'b0;
         o_smi_mode     <= 1'b0;
         o_smi_reg_addr <= 5'd0;
         o_smi_data     <= 16'd0;
         o_req_ack      <= 1'b0;
         o_req_data     <= 16'd0;
         o_init_done    <= 1'b0;
         o_status       <= 16'd0;
      end else begin
         state <= state_next;
         mdc_q <= i_mdc;
         dv_q  <= i_smi_dv;

         if ((state_next != state) || (state == ST_ISSUE)) begin
            edge_cnt <= 16'd0;
         end else if (fall && ((state == ST_STARTUP) || (state == ST_WAIT_DONE))) begin
            edge_cnt <= edge_cnt + 16'd1;
         end

         if (load) begin
            src            <= ld_src;
            o_smi_mode     <= ld_mode;
            o_smi_reg_addr <= ld_reg;
            o_smi_data     <= ld_data;
            cap_done       <= 1'b0;
            if (ld_src == SRC_HOST) begin
               last_host <= 1'b1;
            end else if (ld_src == SRC_POLL) begin
               last_host <= 1'b0;
            end
         end

         if ((state == ST_WAIT_DONE) && !o_smi_mode && i_smi_dv && !dv_q && !cap_done) begin
            cap_done <= 1'b1;
            if (src == SRC_POLL) begin
               o_status <= i_smi_data;
            end else if (src == SRC_HOST) begin
               o_req_data <= i_smi_data;
            end
         end

         o_req_ack <= frame_done && (src == SRC_HOST);

         if (frame_done && (src == SRC_INIT)) begin
            init_idx <= init_idx + 4'd1;
         end
         if (init_finish) begin
            o_init_done <= 1'b1;
         end

         if (o_init_done && fall) begin
            poll_cnt <= (poll_cnt == POLL_LAST) ? 16'd0 : (poll_cnt + 16'd1);
         end
         // A fresh expiry in the completion cycle wins over the clear.
         if (frame_done && (src == SRC_POLL)) begin
            poll_pend <= 1'b0;
         end
         if (poll_expire) begin
            poll_pend <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vsc8541_smi_ctrl.sv
// ============================================================================
// tb_vsc8541_smi_ctrl : directed bench with a small MDIO PHY responder model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vsc8541_smi_ctrl;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_mdc = 1'b1;
   logic        o_smi_en, o_smi_mode;
   logic [4:0]  o_smi_phy_addr, o_smi_reg_addr;
   logic [15:0] o_smi_data;
   logic        i_smi_dv;
   logic [15:0] i_smi_data;
   logic        i_req, i_req_mode;
   logic [4:0]  i_req_reg_addr;
   logic [15:0] i_req_data;
   logic        o_req_ack;
   logic [15:0] o_req_data;
   logic        o_init_done;
   logic [15:0] o_status;
   logic        o_link_up, o_busy;

   vsc8541_smi_ctrl #(
      .PHY_ADDR      (5'd3),
      .INIT_LEN      (2),
      .INIT_TABLE    ({5'd23, 16'h0A00, 5'd0, 16'h8000}),
      .POLL_DIV      (50),
      .STARTUP_EDGES (8),
      .TXN_EDGES     (33)
   ) dut (
      .clk            (clk),
      .i_reset        (i_reset),
      .i_mdc          (i_mdc),
      .o_smi_en       (o_smi_en),
      .o_smi_mode     (o_smi_mode),
      .o_smi_phy_addr (o_smi_phy_addr),
      .o_smi_reg_addr (o_smi_reg_addr),
      .o_smi_data     (o_smi_data),
      .i_smi_dv       (i_smi_dv),
      .i_smi_data     (i_smi_data),
      .i_req          (i_req),
      .i_req_mode     (i_req_mode),
      .i_req_reg_addr (i_req_reg_addr),
      .i_req_data     (i_req_data),
      .o_req_ack      (o_req_ack),
      .o_req_data     (o_req_data),
      .o_init_done    (o_init_done),
      .o_status       (o_status),
      .o_link_up      (o_link_up),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   int falls = 0;
   initial begin
      forever begin
         repeat (2) @(negedge clk);
         i_mdc = ~i_mdc;
         if (!i_mdc) falls++;
      end
   end

   // Frame log written by the PHY model
   logic        fr_mode [$];
   logic [4:0]  fr_reg  [$];
   logic [15:0] fr_data [$];
   int          fr_fall [$];
   int          bad_phy = 0;
   logic [15:0] phy_status;

   initial begin
      i_smi_dv   = 1'b0;
      i_smi_data = 16'd0;
      forever begin
         @(negedge clk);
         if (o_smi_en && !i_reset) begin
            fr_mode.push_back(o_smi_mode);
            fr_reg.push_back(o_smi_reg_addr);
            fr_data.push_back(o_smi_data);
            fr_fall.push_back(falls);
            if (o_smi_phy_addr !== 5'd3) bad_phy++;
            if (!o_smi_mode) begin
               repeat (20) @(negedge i_mdc);
               @(negedge clk);
               i_smi_data = (fr_reg[fr_reg.size()-1] == 5'd1) ? phy_status :
                            (fr_reg[fr_reg.size()-1] == 5'd2) ? 16'h0007 : 16'hDEAD;
               i_smi_dv   = 1'b1;
               repeat (3) @(negedge clk);
               i_smi_dv   = 1'b0;
            end
         end
      end
   end

   // Protocol monitor: field hold, en-while-busy, ack pulse count
   logic        h_mode;
   logic [4:0]  h_reg;
   logic [15:0] h_data;
   int          bad_hold = 0, bad_en = 0, ack_cnt = 0;
   always @(negedge clk) begin
      if (o_smi_en) begin
         h_mode <= o_smi_mode;
         h_reg  <= o_smi_reg_addr;
         h_data <= o_smi_data;
      end
      if (o_busy && !i_reset && ((o_smi_mode !== h_mode) || (o_smi_reg_addr !== h_reg) ||
                                 (o_smi_data !== h_data)))
         bad_hold <= bad_hold + 1;
      if (o_smi_en && o_busy) bad_en <= bad_en + 1;
      if (o_req_ack) ack_cnt <= ack_cnt + 1;
   end

   int n_cmp = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #(600000 * 10);
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   int t, rel_falls, ack_base, base, endi, hosts, polls, run, max_run, dbl_poll;

   initial begin
      i_reset        = 1'b1;
      i_req          = 1'b1;          // host read raised during startup: must be held off
      i_req_mode     = 1'b0;
      i_req_reg_addr = 5'd2;
      i_req_data     = 16'd0;
      phy_status     = 16'h796D;
      repeat (4) @(negedge clk);

      check("rst_en",       o_smi_en,       1'b0);
      check("rst_busy",     o_busy,         1'b0);
      check("rst_init",     o_init_done,    1'b0);
      check("rst_status",   o_status,       16'h0);
      check("rst_link",     o_link_up,      1'b0);
      check("rst_ack",      o_req_ack,      1'b0);
      check("rst_reqdata",  o_req_data,     16'h0);
      check("rst_phyaddr",  o_smi_phy_addr, 5'd3);
      check("rst_mode",     o_smi_mode,     1'b0);

      @(negedge i_mdc); @(negedge clk);
      i_reset = 1'b0; rel_falls = falls;

      t = 0; while (!o_init_done && t < 3000) begin @(negedge clk); t++; end
      check("init_done_seen", o_init_done, 1'b1);
      check("init_nframes", fr_reg.size(), 2);
      check("no_host_before_init", ack_cnt, 0);
      if (fr_reg.size() >= 2) begin
         check("init0_delay", fr_fall[0] - rel_falls, 8);
         check("init0_mode",  fr_mode[0], 1'b1);
         check("init0_reg",   fr_reg[0],  5'd0);
         check("init0_data",  fr_data[0], 16'h8000);
         check("init1_mode",  fr_mode[1], 1'b1);
         check("init1_reg",   fr_reg[1],  5'd23);
         check("init1_data",  fr_data[1], 16'h0A00);
         check("init_spacing_ge33", (fr_fall[1] - fr_fall[0]) >= 33, 1'b1);
      end

      // Held-off host read is served first
      t = 0; while (!o_req_ack && t < 1000) begin @(negedge clk); t++; end
      check("hostrd_ack_seen", o_req_ack, 1'b1);
      check("hostrd_frame_idx", fr_reg.size(), 3);
      check("hostrd_reg",  fr_reg[fr_reg.size()-1],  5'd2);
      check("hostrd_mode", fr_mode[fr_reg.size()-1], 1'b0);
      check("hostrd_data", o_req_data, 16'h0007);
      @(negedge clk);
      i_req = 1'b0;
      check("hostrd_ack_one_cycle", o_req_ack, 1'b0);

      // Status poll, link up then down
      t = 0; while (o_status == 16'h0 && t < 2000) begin @(negedge clk); t++; end
      check("poll_status_up", o_status, 16'h796D);
      check("poll_link_up",   o_link_up, 1'b1);
      check("poll_reg",  fr_reg[fr_reg.size()-1],  5'd1);
      check("poll_mode", fr_mode[fr_reg.size()-1], 1'b0);
      phy_status = 16'h7969;
      t = 0; while (o_link_up && t < 3000) begin @(negedge clk); t++; end
      check("poll_link_down", o_link_up, 1'b0);
      check("poll_status_dn", o_status, 16'h7969);

      // Host write
      ack_base       = ack_cnt;
      i_req_mode     = 1'b1;
      i_req_reg_addr = 5'd31;
      i_req_data     = 16'h0010;
      i_req          = 1'b1;
      t = 0; while (!o_req_ack && t < 2000) begin @(negedge clk); t++; end
      check("hostwr_ack_seen", o_req_ack, 1'b1);
      check("hostwr_mode", fr_mode[fr_reg.size()-1], 1'b1);
      check("hostwr_reg",  fr_reg[fr_reg.size()-1],  5'd31);
      check("hostwr_data", fr_data[fr_reg.size()-1], 16'h0010);
      @(negedge clk);
      i_req = 1'b0;
      repeat (5) @(negedge clk);
      check("hostwr_one_ack", ack_cnt - ack_base, 1);

      // Continuous host reads competing with polls
      i_req_mode     = 1'b0;
      i_req_reg_addr = 5'd2;
      ack_base       = ack_cnt;
      base           = fr_reg.size();
      i_req          = 1'b1;
      t = 0; while (fr_reg.size() < base + 10 && t < 6000) begin @(negedge clk); t++; end
      check("fair_frames_seen", fr_reg.size() >= base + 10, 1'b1);
      t = 0; while (!o_req_ack && t < 1000) begin @(negedge clk); t++; end
      check("fair_final_ack", o_req_ack, 1'b1);
      endi = fr_reg.size();
      @(negedge clk);
      i_req = 1'b0;
      repeat (3) @(negedge clk);
      hosts = 0; polls = 0; run = 0; max_run = 0; dbl_poll = 0;
      for (int i = base; i < endi; i++) begin
         if (fr_reg[i] == 5'd1) begin
            polls++;
            if (i > base && fr_reg[i-1] == 5'd1) dbl_poll++;
            run = 0;
         end else begin
            hosts++;
            run++;
            if (run > max_run) max_run = run;
         end
      end
      check("fair_polls_ge3",    polls >= 3, 1'b1);
      check("fair_host_run_le2", max_run <= 2, 1'b1);
      check("fair_no_dbl_poll",  dbl_poll, 0);
      check("fair_ack_per_host", ack_cnt - ack_base, hosts);

      // Reset in the middle of an init write frame
      t = 0; while (o_busy && t < 200) begin @(negedge clk); t++; end
      i_reset = 1'b1;
      repeat (3) @(negedge clk);
      fr_mode.delete(); fr_reg.delete(); fr_data.delete(); fr_fall.delete();
      @(negedge i_mdc); @(negedge clk);
      i_reset = 1'b0; rel_falls = falls;
      t = 0; while (fr_reg.size() < 1 && t < 200) begin @(negedge clk); t++; end
      check("mid_first_en", fr_reg.size(), 1);
      repeat (10) @(negedge i_mdc);
      @(negedge clk);
      check("mid_busy_before", o_busy, 1'b1);
      i_reset = 1'b1;
      @(negedge clk);
      check("mid_rst_busy",    o_busy,     1'b0);
      check("mid_rst_en",      o_smi_en,   1'b0);
      check("mid_rst_mode",    o_smi_mode, 1'b0);
      check("mid_rst_data",    o_smi_data, 16'h0);
      check("mid_rst_status",  o_status,   16'h0);
      check("mid_rst_reqdata", o_req_data, 16'h0);
      check("mid_rst_link",    o_link_up,  1'b0);
      repeat (2) @(negedge clk);
      fr_mode.delete(); fr_reg.delete(); fr_data.delete(); fr_fall.delete();
      @(negedge i_mdc); @(negedge clk);
      i_reset = 1'b0; rel_falls = falls;
      t = 0; while (!o_init_done && t < 3000) begin @(negedge clk); t++; end
      check("re_init_done", o_init_done, 1'b1);
      check("re_nframes", fr_reg.size(), 2);
      if (fr_reg.size() >= 2) begin
         check("re_init0_delay", fr_fall[0] - rel_falls, 8);
         check("re_init0_reg",   fr_reg[0],  5'd0);
         check("re_init0_data",  fr_data[0], 16'h8000);
         check("re_init1_reg",   fr_reg[1],  5'd23);
         check("re_init1_data",  fr_data[1], 16'h0A00);
      end

      repeat (4) @(negedge clk);
      check("phy_addr_all_frames", bad_phy,  0);
      check("fields_held",         bad_hold, 0);
      check("no_en_while_busy",    bad_en,   0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
